// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding,
// line-level framing constants and a small stop-bit helper.
package serial_frame_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // A frame is accepted only when the sampled stop bit matches the idle level.
  function automatic logic stop_bit_ok(input logic stop_sample);
    return (stop_sample == STOP_BIT);
  endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Serial link bundle: the line-side inputs of the receiver and its
// parallel-word outputs.
interface serial_frame_receiver_if #(
  parameter int WIDTH = 4
);
  logic             bit_en;
  logic             serial_in;
  logic             msb_first;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output bit_en, serial_in, msb_first,
    input  data_out, data_valid, frame_err, busy
  );

  modport slave (
    input  bit_en, serial_in, msb_first,
    output data_out, data_valid, frame_err, busy
  );
endinterface

// File: rtl/serial_frame_receiver_chk.sv
// Property checker for the serial frame receiver output pulses.
module serial_frame_receiver_chk (
  input logic clk,
  input logic reset,
  input logic data_valid,
  input logic frame_err
);

  a_pulse_exclusive: assert property (
    @(posedge clk) disable iff (reset) !(data_valid && frame_err)
  );

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial-in/parallel-out frame receiver: start bit, WIDTH data bits (MSB- or
// LSB-first, fixed per frame), stop bit; emits a word pulse or a framing error.
module serial_frame_receiver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic                  clk,
  input logic                  reset,
  serial_frame_receiver_if.slave bus
);
  import serial_frame_receiver_pkg::*;

  rx_state_e        state_r;
  rx_state_e        state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] count_inc_s;
  logic             dir_r;
  logic             dir_nxt_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] data_out_r;
  logic             data_valid_r;
  logic             frame_err_r;
  logic             busy_r;
  logic             stop_strobe_s;
  logic             frame_good_s;
  logic             frame_bad_s;

  assign count_inc_s   = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign stop_strobe_s = (state_r == ST_STOP) && bus.bit_en;
  assign frame_good_s  = stop_strobe_s && stop_bit_ok(bus.serial_in);
  assign frame_bad_s   = stop_strobe_s && !stop_bit_ok(bus.serial_in);

  // FSM, bit counter and direction latch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= {CNT_W{1'b0}};
      dir_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      dir_r   <= dir_nxt_s;
    end
  end

  // Next-state logic; direction is captured only on the start bit
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    dir_nxt_s   = dir_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.bit_en && (bus.serial_in == START_BIT)) begin
          state_nxt_s = ST_DATA;
          count_nxt_s = {CNT_W{1'b0}};
          dir_nxt_s   = bus.msb_first;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bus.bit_en) begin
          count_nxt_s = count_inc_s;
          if (count_inc_s == CNT_W'(WIDTH)) begin
            state_nxt_s = ST_STOP;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (bus.bit_en) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Shift register: dir_r=1 shifts toward the MSB, dir_r=0 toward the LSB
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_r <= {WIDTH{1'b0}};
    end else if ((state_r == ST_DATA) && bus.bit_en) begin
      if (dir_r) begin
        shreg_r <= {shreg_r[WIDTH-2:0], bus.serial_in};
      end else begin
        shreg_r <= {bus.serial_in, shreg_r[WIDTH-1:1]};
      end
    end else begin
      shreg_r <= shreg_r;
    end
  end

  // Output register: word capture, single-cycle pulses and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r   <= {WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      data_valid_r <= frame_good_s;
      frame_err_r  <= frame_bad_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      if (frame_good_s) begin
        data_out_r <= shreg_r;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.busy       = busy_r;

endmodule
